// File: rtl/stream_step_controller.sv
// stream_step_controller
//   Packs a byte stream into 16-bit symbol pairs for a two-symbol automaton.
//   Each character gets exactly one step strobe. Every step that sees the
//   automaton report line high pushes the character offset into a show-ahead
//   report FIFO. A job is framed by start -> flush -> characters -> done.
module stream_step_controller #(
  parameter int unsigned RPT_DEPTH = 8,
  parameter int unsigned OFS_W     = 16,
  parameter logic [7:0]  PAD_BYTE  = 8'h00
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [7:0]       in_byte,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [15:0]      character,
  output logic             step,
  output logic             flush,
  input  logic             result,
  output logic [OFS_W-1:0] rpt_offset,
  output logic             rpt_valid,
  input  logic             rpt_ready,
  output logic             busy,
  output logic             done,
  output logic             overflow
);

  localparam int PTR_W = (RPT_DEPTH > 1) ? $clog2(RPT_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RPT_DEPTH);
  localparam logic [OFS_W-1:0] OFS_MAX = {OFS_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FLUSH  = 3'd1,
    S_GET_HI = 3'd2,
    S_GET_LO = 3'd3,
    S_STEP   = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t             state_r;
  state_t             state_s;
  logic [15:0]        character_r;
  logic               last_r;
  logic [OFS_W-1:0]   offset_r;
  logic               overflow_r;
  logic [OFS_W-1:0]   mem_r [RPT_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [CNT_W-1:0]   fifo_count_r;

  logic               in_ready_s;
  logic               step_s;
  logic               flush_s;
  logic               busy_s;
  logic               done_s;
  logic               start_job_s;
  logic               accept_hi_s;
  logic               accept_lo_s;
  logic               rpt_valid_s;
  logic               pop_s;
  logic               push_s;
  logic               can_push_s;

  // FIFO status: a pop frees a slot in the same cycle, so a full FIFO can still accept a push
  always_comb begin
    rpt_valid_s = (fifo_count_r != {CNT_W{1'b0}});
    pop_s       = rpt_valid_s && rpt_ready;
    can_push_s  = (fifo_count_r < DEPTH_C) || pop_s;
    push_s      = step_s && result;
  end

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and strobe decode; stepping waits until a report could be stored
  always_comb begin
    state_s     = state_r;
    in_ready_s  = 1'b0;
    step_s      = 1'b0;
    flush_s     = 1'b0;
    busy_s      = 1'b1;
    done_s      = 1'b0;
    start_job_s = 1'b0;
    accept_hi_s = 1'b0;
    accept_lo_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        busy_s = 1'b0;
        if (start) begin
          start_job_s = 1'b1;
          state_s     = S_FLUSH;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_FLUSH: begin
        flush_s = 1'b1;
        state_s = S_GET_HI;
      end
      S_GET_HI: begin
        in_ready_s = 1'b1;
        if (in_valid) begin
          accept_hi_s = 1'b1;
          state_s     = in_last ? S_STEP : S_GET_LO;
        end else begin
          state_s = S_GET_HI;
        end
      end
      S_GET_LO: begin
        in_ready_s = 1'b1;
        if (in_valid) begin
          accept_lo_s = 1'b1;
          state_s     = S_STEP;
        end else begin
          state_s = S_GET_LO;
        end
      end
      S_STEP: begin
        if (can_push_s) begin
          step_s  = 1'b1;
          state_s = last_r ? S_DONE : S_GET_HI;
        end else begin
          state_s = S_STEP;
        end
      end
      S_DONE: begin
        busy_s = 1'b0;
        done_s = 1'b1;
        if (start) begin
          start_job_s = 1'b1;
          state_s     = S_FLUSH;
        end else begin
          state_s = S_DONE;
        end
      end
      default: begin
        busy_s  = 1'b0;
        state_s = S_IDLE;
      end
    endcase
  end

  // Character assembly: first byte to the high half, pad the low half on an odd end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      character_r <= 16'h0000;
      last_r      <= 1'b0;
    end else if (accept_hi_s) begin
      character_r[15:8] <= in_byte;
      if (in_last) begin
        character_r[7:0] <= PAD_BYTE;
        last_r           <= 1'b1;
      end else begin
        last_r <= 1'b0;
      end
    end else if (accept_lo_s) begin
      character_r[7:0] <= in_byte;
      last_r           <= in_last;
    end else begin
      last_r <= last_r;
    end
  end

  // Character offset counter and sticky wrap flag, both cleared when a job starts
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      offset_r   <= {OFS_W{1'b0}};
      overflow_r <= 1'b0;
    end else if (start_job_s) begin
      offset_r   <= {OFS_W{1'b0}};
      overflow_r <= 1'b0;
    end else if (step_s) begin
      offset_r <= offset_r + {{(OFS_W-1){1'b0}}, 1'b1};
      if (offset_r == OFS_MAX) begin
        overflow_r <= 1'b1;
      end else begin
        overflow_r <= overflow_r;
      end
    end else begin
      offset_r <= offset_r;
    end
  end

  // Report storage; contents are only meaningful between the pointers, so no reset
  always_ff @(posedge clock) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= offset_r;
    end
  end

  // Report FIFO pointers and occupancy; simultaneous push and pop leaves the count unchanged
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_r     <= {PTR_W{1'b0}};
      rd_ptr_r     <= {PTR_W{1'b0}};
      fifo_count_r <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
      end
      case ({push_s, pop_s})
        2'b10:   fifo_count_r <= fifo_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        2'b01:   fifo_count_r <= fifo_count_r - {{(CNT_W-1){1'b0}}, 1'b1};
        default: fifo_count_r <= fifo_count_r;
      endcase
    end
  end

  assign in_ready   = in_ready_s;
  assign step       = step_s;
  assign flush      = flush_s;
  assign busy       = busy_s;
  assign done       = done_s;
  assign character  = character_r;
  assign overflow   = overflow_r;
  assign rpt_valid  = rpt_valid_s;
  assign rpt_offset = rpt_valid_s ? mem_r[rd_ptr_r] : {OFS_W{1'b0}};

endmodule
